// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP payload field reader.
package udp_pkg;

   typedef enum logic {UDP_IDLE, UDP_RECV} udp_rx_state_t;

   localparam int UDP_BYTE_W = 8;

endpackage

// File: rtl/udp_field_reader.sv
// Captures a CAPACITY-byte field at OFFSET within a UDP payload packet and
// commits it to a shadow register only when the packet ends with an acceptable length.
module udp_field_reader
   import udp_pkg::*;
#(
   parameter int CAPACITY   = 4,
   parameter int OFFSET     = 0,
   parameter bit STRICT     = 1'b1,
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int LEN_W      = 16
) (
   input  logic                             clk,
   input  logic                             rstn,
   // Stream has no backpressure: a byte is transferred on every edge where
   // valid=1, and a packet is one unbroken run of such edges.
   input  logic                             valid,
   input  logic [UDP_BYTE_W-1:0]            i_data,
   output logic [CAPACITY*UDP_BYTE_W-1:0]   o_data,
   output logic                             o_valid,
   output logic                             err_short,
   output logic                             err_long,
   output logic [LEN_W-1:0]                 o_len,
   output udp_rx_state_t                    dbg_state_o
);

   localparam logic [LEN_W:0]   END_IDX = (LEN_W+1)'(OFFSET + CAPACITY);
   localparam logic [LEN_W:0]   OFS_IDX = (LEN_W+1)'(OFFSET);
   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   udp_rx_state_t                   state_q, state_d;
   logic [LEN_W-1:0]                cnt_q, cnt_d;
   logic                            over_q, over_d;
   logic [UDP_BYTE_W-1:0]           buf_q [CAPACITY];
   logic [UDP_BYTE_W-1:0]           buf_d [CAPACITY];
   logic [CAPACITY*UDP_BYTE_W-1:0]  data_q, data_d;
   logic [LEN_W-1:0]                len_q, len_d;
   logic                            vld_q, vld_d;
   logic                            short_q, short_d;
   logic                            long_q, long_d;

   logic [LEN_W:0]                  byte_idx;
   logic                            take_byte;
   logic                            byte_over;
   logic                            end_edge;
   logic                            pkt_short;
   logic                            pkt_long;
   logic [CAPACITY*UDP_BYTE_W-1:0]  field;

   // Index of the byte on the current edge; a saturated counter never lands
   // inside the capture window again because the over-long flag is already set.
   always_comb begin
      byte_idx  = '0;
      take_byte = 1'b0;
      end_edge  = 1'b0;
      if (state_q == UDP_IDLE) begin
         byte_idx  = '0;
         take_byte = valid;
      end else begin
         byte_idx  = {1'b0, cnt_q};
         take_byte = valid && (cnt_q != CNT_MAX);
         end_edge  = !valid;
      end
   end

   assign byte_over = take_byte && (byte_idx >= END_IDX);
   assign pkt_long  = over_q;
   assign pkt_short = !over_q && ({1'b0, cnt_q} < END_IDX);

   always_comb begin
      field = '0;
      for (int i = 0; i < CAPACITY; i++) begin
         if (BIG_ENDIAN)
            field[(CAPACITY-1-i)*UDP_BYTE_W +: UDP_BYTE_W] = buf_q[i];
         else
            field[i*UDP_BYTE_W +: UDP_BYTE_W] = buf_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      over_d  = over_q;
      data_d  = data_q;
      len_d   = len_q;
      vld_d   = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      for (int i = 0; i < CAPACITY; i++) begin
         buf_d[i] = buf_q[i];
         if (take_byte && (byte_idx == OFS_IDX + (LEN_W+1)'(i)))
            buf_d[i] = i_data;
      end

      case (state_q)
         UDP_IDLE: begin
            if (valid) begin
               state_d = UDP_RECV;
               cnt_d   = LEN_W'(1);
               over_d  = byte_over;
            end
         end
         UDP_RECV: begin
            if (valid) begin
               if (cnt_q != CNT_MAX)
                  cnt_d = cnt_q + LEN_W'(1);
               over_d = over_q | byte_over;
            end else begin
               state_d = UDP_IDLE;
               cnt_d   = '0;
               over_d  = 1'b0;
               len_d   = cnt_q;
               if (pkt_short) begin
                  short_d = 1'b1;
               end else if (pkt_long) begin
                  long_d = 1'b1;
                  if (!STRICT) begin
                     data_d = field;
                     vld_d  = 1'b1;
                  end
               end else begin
                  data_d = field;
                  vld_d  = 1'b1;
               end
            end
         end
         default: state_d = UDP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= UDP_IDLE;
         cnt_q   <= '0;
         over_q  <= 1'b0;
         data_q  <= '0;
         len_q   <= '0;
         vld_q   <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         for (int i = 0; i < CAPACITY; i++)
            buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         over_q  <= over_d;
         data_q  <= data_d;
         len_q   <= len_d;
         vld_q   <= vld_d;
         short_q <= short_d;
         long_q  <= long_d;
         for (int i = 0; i < CAPACITY; i++)
            buf_q[i] <= buf_d[i];
      end
   end

   assign o_data      = data_q;
   assign o_valid     = vld_q;
   assign err_short   = short_q;
   assign err_long    = long_q;
   assign o_len       = len_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/udp_field_reader.md
Name: udp_field_reader

Overview:
- Parametrised successor to the single-buffer UDP byte capture block.
- Extracts a fixed-size field of CAPACITY bytes from a UDP payload byte stream, starting OFFSET bytes into the packet.
- Checks the packet length and commits the field to a stable shadow output only when the packet completes.
- Sits after the UDP payload demux and feeds control/config registers (e.g. target coordinates) that must never see partial updates.

Parameters:
- CAPACITY, 4, field size in bytes (>=1)
- OFFSET, 0, payload bytes skipped before capture begins (>=0)
- STRICT, 1, 1: commit only on exact length; 0: also commit over-long packets (first CAPACITY bytes after OFFSET)
- BIG_ENDIAN, 1, 1: first captured byte lands in o_data MSB; 0: first captured byte lands in o_data[7:0]
- LEN_W, 16, width of the packet length counter/output

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- valid  input  1  payload byte strobe; a packet is one contiguous run of valid=1 cycles
- i_data  input  8  payload byte, sampled when valid=1
- o_data  output  CAPACITY*8  last committed field; reset 0
- o_valid  output  1  one-cycle pulse when o_data is updated; reset 0
- err_short  output  1  one-cycle pulse: packet shorter than OFFSET+CAPACITY; reset 0
- err_long  output  1  one-cycle pulse: packet longer than OFFSET+CAPACITY; reset 0
- o_len  output  LEN_W  length of the last finished packet, saturating; reset 0

Behaviour:
- One clock `clk`; reset `rstn` is asynchronous and active-low. Reset clears state, counter, capture buffer, o_data, o_len and all pulses.
- FSM with two states:
  - IDLE -> RECV on valid=1. That byte is byte index 0; the counter becomes 1.
  - RECV stays in RECV while valid=1, incrementing the counter.
  - RECV -> IDLE on the first edge that samples valid=0. This edge is the "end edge".
- Byte k (0-based):
  - k < OFFSET: discarded.
  - OFFSET <= k < OFFSET+CAPACITY: written to buf[k-OFFSET].
  - k >= OFFSET+CAPACITY: not stored; marks the packet over-long.
  - All CAPACITY slots are usable; no off-by-one loss of the last slot.
- Counter is LEN_W bits and saturates at 2^LEN_W-1 (no wrap). The over-long flag is sticky within a packet, so saturation never hides an overflow.
- At the end edge, with N = packet length and E = OFFSET+CAPACITY:
  - N == E: o_data <= buf (ordered per BIG_ENDIAN); o_valid=1.
  - N < E: err_short=1; o_data is unchanged.
  - N > E: err_long=1. If STRICT=0, also o_data <= buf and o_valid=1; if STRICT=1, o_data is unchanged.
  - o_len <= N in every case.
- Pulses are registered. They are high for exactly the one cycle following the end edge. At most one of err_short/err_long is high.
- Latency: the last byte is sampled at edge t; the end edge is t+1; o_valid/o_data/o_len are visible after t+1.
- Back-to-back packets: the minimum gap is one valid=0 cycle. The commit of packet A overlaps the IDLE cycle, and packet B may start on the next edge.
- Buffer bytes not written in a short packet are don't-care; they are never committed.
- Reset mid-packet: the partial packet is discarded, with no pulses. If valid=1 at reset release, the following bytes form a new packet starting at index 0.
- o_data is stable between commits. It never shows a partially written field.

Decomposition:
- Package udp_pkg holds:
  - typedef enum logic {UDP_IDLE, UDP_RECV} udp_rx_state_t;
  - localparam UDP_BYTE_W = 8.
- No sub-module. The capture buffer, counter and commit logic are one block, roughly 150-200 lines.

Test Plan (CAPACITY=4, OFFSET=2 unless stated):
- Exact packet A0,A1,11,22,33,44 -> o_data=0x11223344, o_valid one cycle after the end edge, o_len=6, no errors.
- Short packet of 5 bytes after the exact packet above -> err_short pulse, o_valid=0, o_data stays 0x11223344, o_len=5.
- Long packet of 8 bytes A0,A1,55,66,77,88,99,AA:
  - STRICT=1 -> err_long, o_data unchanged, o_len=8.
  - STRICT=0 -> err_long plus o_valid, o_data=0x55667788.
- Two exact packets separated by a single valid=0 cycle -> two o_valid pulses, with o_data updated to each field in turn.
- rstn asserted after 3 bytes, released with valid=1 and 6 more bytes -> o_data=0 during reset, no pulse for the partial packet, then a normal commit of bytes 2-5 of the new run.
- BIG_ENDIAN=0, OFFSET=0, bytes 11,22,33,44 -> o_data=0x44332211; CAPACITY=1 single byte 5A -> o_data=0x5A.
